// File: rtl/jk_bank_driver_if.sv
// Command handshake between a command source and the jk bank driver.
// master drives opcode/data/valid, slave returns ready.
interface jk_bank_driver_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd;
    logic [WIDTH-1:0] cmd_data;

    modport master (output cmd_valid, output cmd, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd, input cmd_data, output cmd_ready);
endinterface

// File: rtl/jk_bank_driver.sv
// Drives j/k of a WIDTH-bit jk_ff bank from commands; bank updates 1 edge after accept, INC/DEC N step once per edge.
// Backpressure: cmd_ready only in IDLE, so single-shot ops take 2 cycles and N-step counts take N+1.
module jk_bank_driver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    jk_bank_driver_if.slave  cmd_if,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q_mirror,
    output logic             wrap,
    output logic             cmd_err
);
    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_SET  = 3'd1;
    localparam logic [2:0] OP_CLR  = 3'd2;
    localparam logic [2:0] OP_TOG  = 3'd3;
    localparam logic [2:0] OP_LOAD = 3'd4;
    localparam logic [2:0] OP_INC  = 3'd5;
    localparam logic [2:0] OP_DEC  = 3'd6;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        COUNT = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] step_cnt;
    logic             down;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] pat_first;
    logic [WIDTH-1:0] pat_next;

    // Toggle mask for one binary count step: bit i flips when all lower bits
    // are 1 (up) or all lower bits are 0 (down).
    function automatic logic [WIDTH-1:0] step_pat(input logic [WIDTH-1:0] q, input logic dn);
        logic [WIDTH-1:0] t;
        logic             carry;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t[i]  = carry;
            carry = carry & (dn ? ~q[i] : q[i]);
        end
        return t;
    endfunction

    // In COUNT, j == k == the toggle mask the bank applies on this edge.
    assign q_step    = q_mirror ^ j;
    assign pat_first = step_pat(q_mirror, cmd_if.cmd == OP_DEC);
    assign pat_next  = step_pat(q_step, down);

    assign cmd_if.cmd_ready = (state == IDLE);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            j        <= '0;
            k        <= '0;
            q_mirror <= '0;
            wrap     <= 1'b0;
            cmd_err  <= 1'b0;
            step_cnt <= '0;
            down     <= 1'b0;
        end else begin
            wrap    <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_if.cmd_valid) begin
                        state <= DRIVE;
                        case (cmd_if.cmd)
                            OP_HOLD: begin
                                j <= '0;
                                k <= '0;
                            end
                            OP_SET: begin
                                j <= cmd_if.cmd_data;
                                k <= '0;
                            end
                            OP_CLR: begin
                                j <= '0;
                                k <= cmd_if.cmd_data;
                            end
                            OP_TOG: begin
                                j <= cmd_if.cmd_data;
                                k <= cmd_if.cmd_data;
                            end
                            OP_LOAD: begin
                                j <= cmd_if.cmd_data;
                                k <= ~cmd_if.cmd_data;
                            end
                            OP_INC, OP_DEC: begin
                                down <= (cmd_if.cmd == OP_DEC);
                                if (cmd_if.cmd_data == '0) begin
                                    j <= '0;
                                    k <= '0;
                                end else begin
                                    j        <= pat_first;
                                    k        <= pat_first;
                                    step_cnt <= cmd_if.cmd_data - ONE;
                                    state    <= COUNT;
                                end
                            end
                            default: begin
                                j       <= '0;
                                k       <= '0;
                                cmd_err <= 1'b1;
                            end
                        endcase
                    end
                end
                DRIVE: begin
                    q_mirror <= (j & ~q_mirror) | (~k & q_mirror);
                    j        <= '0;
                    k        <= '0;
                    state    <= IDLE;
                end
                COUNT: begin
                    q_mirror <= q_step;
                    wrap     <= down ? (q_mirror == '0) : (&q_mirror);
                    if (step_cnt != '0) begin
                        j        <= pat_next;
                        k        <= pat_next;
                        step_cnt <= step_cnt - ONE;
                    end else begin
                        j     <= '0;
                        k     <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    j     <= '0;
                    k     <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: a behavioural jk_ff bank on j/k, a command table, and a completion scoreboard.
module tb_jk_bank_driver;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clear;
    logic [W-1:0] j, k, q_mirror, q_bank;
    logic         wrap, cmd_err;

    always #5 clk = ~clk;

    jk_bank_driver_if #(.WIDTH(W)) bus ();

    jk_bank_driver #(.WIDTH(W)) dut (
        .clk      (clk),
        .clear    (clear),
        .cmd_if   (bus),
        .j        (j),
        .k        (k),
        .q_mirror (q_mirror),
        .wrap     (wrap),
        .cmd_err  (cmd_err)
    );

    // Behavioural bank of jk flip-flops sharing clk and clear
    always @(posedge clk or negedge clear) begin
        if (!clear) q_bank <= '0;
        else begin
            for (int i = 0; i < W; i++) begin
                case ({j[i], k[i]})
                    2'b10:   q_bank[i] <= 1'b1;
                    2'b01:   q_bank[i] <= 1'b0;
                    2'b11:   q_bank[i] <= ~q_bank[i];
                    default: q_bank[i] <= q_bank[i];
                endcase
            end
        end
    end

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] data;
        logic [W-1:0] ej;
        logic [W-1:0] ek;
        logic [W-1:0] eq;
        int           elow;
        int           ewrap;
        int           eerr;
    } vec_t;

    typedef struct {
        logic [W-1:0] eq;
        int           elow;
        int           ewrap;
        int           eerr;
        int           idx;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Completion monitor: a transaction is the run of cycles with cmd_ready low
    bit   in_txn = 1'b0;
    int   low_cnt, wrap_cnt, err_cnt;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!clear) begin
            in_txn = 1'b0;
        end else if (!bus.cmd_ready) begin
            if (!in_txn) begin
                in_txn   = 1'b1;
                low_cnt  = 0;
                wrap_cnt = 0;
                err_cnt  = 0;
            end
            low_cnt++;
            wrap_cnt += int'(wrap);
            err_cnt  += int'(cmd_err);
        end else if (in_txn) begin
            in_txn = 1'b0;
            wrap_cnt += int'(wrap);
            err_cnt  += int'(cmd_err);
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_underflow: got completion with no expectation queued");
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("v%0d_q_mirror", mon_e.idx), q_mirror, mon_e.eq);
                chk($sformatf("v%0d_bank_q", mon_e.idx), q_bank, mon_e.eq);
                chk($sformatf("v%0d_busy_cycles", mon_e.idx), low_cnt, mon_e.elow);
                chk($sformatf("v%0d_wrap_pulses", mon_e.idx), wrap_cnt, mon_e.ewrap);
                chk($sformatf("v%0d_err_pulses", mon_e.idx), err_cnt, mon_e.eerr);
            end
        end
    end

    // Called on a negedge; cmd_valid stays up while the DUT is busy.
    task automatic send(input vec_t v, input int idx);
        int   guard;
        exp_t e;
        guard = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd       = v.op;
        bus.cmd_data  = v.data;
        while (!bus.cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.cmd_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL v%0d_ready_timeout: got cmd_ready=0 after %0d cycles, expected 1", idx, guard);
            bus.cmd_valid = 1'b0;
            return;
        end
        e = '{v.eq, v.elow, v.ewrap, v.eerr, idx};
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk($sformatf("v%0d_j", idx), j, v.ej);
        chk($sformatf("v%0d_k", idx), k, v.ek);
    endtask

    task automatic wait_idle(input string nm);
        int guard;
        guard = 0;
        while (!bus.cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk(nm, bus.cmd_ready, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    vec_t tv[17];

    initial begin
        // op, data, j, k, q after, busy cycles, wraps, errs
        tv[0]  = '{3'd4, 4'b1010, 4'b1010, 4'b0101, 4'b1010, 1, 0, 0};
        tv[1]  = '{3'd1, 4'b0001, 4'b0001, 4'b0000, 4'b1011, 1, 0, 0};
        tv[2]  = '{3'd2, 4'b1000, 4'b0000, 4'b1000, 4'b0011, 1, 0, 0};
        tv[3]  = '{3'd3, 4'b0110, 4'b0110, 4'b0110, 4'b0101, 1, 0, 0};
        tv[4]  = '{3'd4, 4'b1110, 4'b1110, 4'b0001, 4'b1110, 1, 0, 0};
        tv[5]  = '{3'd5, 4'd3,    4'b0001, 4'b0001, 4'b0001, 3, 1, 0};
        tv[6]  = '{3'd4, 4'b0001, 4'b0001, 4'b1110, 4'b0001, 1, 0, 0};
        tv[7]  = '{3'd6, 4'd2,    4'b0001, 4'b0001, 4'b1111, 2, 1, 0};
        tv[8]  = '{3'd5, 4'd0,    4'b0000, 4'b0000, 4'b1111, 1, 0, 0};
        tv[9]  = '{3'd7, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 1, 0, 1};
        tv[10] = '{3'd0, 4'b0101, 4'b0000, 4'b0000, 4'b1111, 1, 0, 0};
        tv[11] = '{3'd6, 4'd1,    4'b0001, 4'b0001, 4'b1110, 1, 0, 0};
        tv[12] = '{3'd5, 4'd1,    4'b0001, 4'b0001, 4'b1111, 1, 0, 0};
        tv[13] = '{3'd5, 4'd1,    4'b1111, 4'b1111, 4'b0000, 1, 1, 0};
        tv[14] = '{3'd6, 4'd15,   4'b1111, 4'b1111, 4'b0001, 15, 1, 0};
        tv[15] = '{3'd3, 4'b1111, 4'b1111, 4'b1111, 4'b1110, 1, 0, 0};
        tv[16] = '{3'd4, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1, 0, 0};

        clear         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 3'd0;
        bus.cmd_data  = '0;

        #8;
        chk("rst_q_mirror_in_reset", q_mirror, 0);
        chk("rst_j_in_reset", j, 0);
        #4 clear = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_j", j, 0);
        chk("rst_k", k, 0);
        chk("rst_q_mirror", q_mirror, 0);
        chk("rst_bank_q", q_bank, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_cmd_err", cmd_err, 0);

        for (int i = 0; i < 17; i++) send(tv[i], i);
        wait_idle("table_drain_ready");

        // INC 10 from 0000, abort with clear after the third step
        bus.cmd_valid = 1'b1;
        bus.cmd       = 3'd5;
        bus.cmd_data  = 4'd10;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("abort_first_j", j, 4'b0001);
        chk("abort_first_k", k, 4'b0001);
        chk("abort_busy", bus.cmd_ready, 0);
        @(negedge clk);
        chk("abort_step1_q", q_mirror, 4'b0001);
        @(negedge clk);
        chk("abort_step2_q", q_mirror, 4'b0010);
        @(negedge clk);
        chk("abort_step3_q", q_mirror, 4'b0011);
        chk("abort_step3_bank", q_bank, 4'b0011);
        #2 clear = 1'b0;
        #1;
        chk("abort_j", j, 0);
        chk("abort_k", k, 0);
        chk("abort_q_mirror", q_mirror, 0);
        chk("abort_bank_q", q_bank, 0);
        chk("abort_ready", bus.cmd_ready, 1);
        @(negedge clk);
        #2 clear = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_abort_q_mirror", q_mirror, 0);
        chk("post_abort_bank_q", q_bank, 0);
        chk("post_abort_j", j, 0);
        chk("post_abort_ready", bus.cmd_ready, 1);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Command-driven control stage sitting directly upstream of a bank of WIDTH jk_ff flip-flops.
- Accepts hold/set/clear/toggle/load/increment/decrement commands over a valid/ready handshake and drives per-bit j/k vectors so the bank performs the operation on its next posedge clk.
- Keeps a mirror register that tracks the bank's q, used to compute counting patterns and exported for checking.
- The bank shares clk and clear with this block.

Parameters:
- WIDTH, 4, number of jk_ff stages driven; also the width of cmd_data, j, k and q_mirror.

Ports:
- clk  input  1  rising-edge clock, shared with the jk_ff bank
- clear  input  1  asynchronous active-low reset, shared with the jk_ff bank
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command this cycle
- cmd  input  3  opcode: 0 HOLD, 1 SET, 2 CLR, 3 TOG, 4 LOAD, 5 INC, 6 DEC, 7 reserved
- cmd_data  input  WIDTH  bit mask (SET/CLR/TOG), value (LOAD), or step count (INC/DEC)
- j  output  WIDTH  registered J drive to bank bit i
- k  output  WIDTH  registered K drive to bank bit i
- q_mirror  output  WIDTH  expected bank q after all edges so far
- wrap  output  1  one-cycle pulse: an INC step from all-ones to 0, or a DEC step from 0 to all-ones, was just captured
- cmd_err  output  1  one-cycle pulse: opcode 7 was accepted

Behaviour:
- Reset (clear=0, asynchronous, any state): j=0, k=0, q_mirror=0, wrap=0, cmd_err=0, state IDLE, step counter 0. cmd_ready=1 once clear is high. The bank clears at the same time, so the mirror stays consistent.
- FSM states: IDLE, DRIVE, COUNT.
- cmd_ready=1 only in IDLE. A command is accepted on a posedge with cmd_valid & cmd_ready. A held cmd_valid with no ready has no effect.
- Single-shot ops (HOLD/SET/CLR/TOG/LOAD): on the accept edge, j/k are loaded and the state goes IDLE->DRIVE.
  - HOLD: j=0, k=0
  - SET: j=m, k=0
  - CLR: j=0, k=m
  - TOG: j=m, k=m
  - LOAD: j=v, k=~v
- At the next edge (DRIVE->IDLE), the bank captures. q_mirror <= JK rule applied per bit (00 hold, 10 set, 01 clear, 11 toggle). j/k return to 0.
- Single-shot throughput: one command per 2 cycles. Latency from accept edge to bank q update is 1 edge.
- INC/DEC with cmd_data=N:
  - N=0: completes as HOLD (IDLE->DRIVE, j=k=0).
  - N>0: on the accept edge, j=k=t, where t is the toggle pattern for one step from q_mirror.
    - INC: t[i] = AND of q_mirror[i-1:0], with t[0]=1.
    - DEC: t[i] = NOR of q_mirror[i-1:0], with t[0]=1.
  - Step counter is loaded with N-1 and the state goes to COUNT.
- In COUNT, each edge does the following:
  - q_mirror <= q_mirror ^ t.
  - If the counter is nonzero: j=k <= pattern computed from the post-edge mirror value, and the counter decrements.
  - If the counter is zero: j=k <= 0 and the state goes to IDLE.
  - Back-to-back steps, one per cycle. N steps occupy N+1 cycles before cmd_ready returns.
- wrap: pulses in the cycle after the edge where the mirror goes 1..1->0 (INC) or 0->1..1 (DEC). Steps wrap modulo 2^WIDTH.
- Opcode 7: treated as HOLD. cmd_err pulses for 1 cycle after the accept edge.
- Invariant: q_mirror equals bank q after every edge, provided no other agent drives the bank.
- clear asserted mid-COUNT: aborts immediately to the reset state. The remaining steps are discarded.

Test Plan:
- Reset then LOAD 4'b1010 -> j=1010, k=0101 for exactly 1 cycle; bank q and q_mirror = 1010; cmd_ready low for 1 cycle.
- From 1010: SET 0001, CLR 1000, TOG 0110 -> q_mirror sequence 1011, 0011, 0101; bank q matches after each.
- LOAD 1110 then INC N=3 -> q steps 1111, 0000, 0001 on consecutive edges; wrap pulses once after the 0000 edge; cmd_ready returns after 4 cycles.
- LOAD 0001 then DEC N=2 -> 0000, 1111; wrap pulses after the 1111 edge; INC N=0 -> no change, ready after 2 cycles.
- cmd=7 with cmd_data=1111 -> j=k=0, cmd_err pulses once, q unchanged; cmd_valid held while busy -> ignored until cmd_ready=1.
- INC N=10 from 0000, clear pulsed low after the 3rd step -> j/k/q_mirror go to 0 asynchronously, bank q=0, FSM IDLE, no further toggles.
